mem_stage: RTL and testbench

//  Memory-access pipeline stage; the consumer end of the EXE->MEM bus and the data-SRAM read path.
//  - Accepts instructions from EXE over a valid/allowin handshake.
//  - Picks up data_sram_rdata for the load EXE issued in the previous cycle.
//  - Aligns, sign- or zero-extends load data and selects the final result.
//  - Forwards that result to WB and to the decode hazard/forward logic.

---
 rtl/mem_stage_if.sv | 43 ++++
 rtl/mem_stage.sv | 130 +++++++++++++
 tb/tb_mem_stage.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// EXE->MEM->WB handshake, bus and SRAM read-data bundle for mem_stage.
// slave = the MEM stage itself; master = the EXE/WB/SRAM side.
interface mem_stage_if #(
    parameter int EXE_TO_MEM_BUS_WD = 78,
    parameter int MEM_TO_WB_BUS_WD  = 70
);
    logic                         exe_to_mem_valid;
    logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus;
    logic                         mem_allowin;
    logic [31:0]                  data_sram_rdata;
    logic                         wb_allowin;
    logic                         mem_to_wb_valid;
    logic [MEM_TO_WB_BUS_WD-1:0]  mem_to_wb_bus;
    logic                         gr_we_mem;
    logic [4:0]                   dest_mem;
    logic [31:0]                  forward_data_mem;

    modport slave (
        input  exe_to_mem_valid,
        input  exe_to_mem_bus,
        output mem_allowin,
        input  data_sram_rdata,
        input  wb_allowin,
        output mem_to_wb_valid,
        output mem_to_wb_bus,
        output gr_we_mem,
        output dest_mem,
        output forward_data_mem
    );

    modport master (
        output exe_to_mem_valid,
        output exe_to_mem_bus,
        input  mem_allowin,
        output data_sram_rdata,
        output wb_allowin,
        input  mem_to_wb_valid,
        input  mem_to_wb_bus,
        input  gr_we_mem,
        input  dest_mem,
        input  forward_data_mem
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: load alignment/extension and result select.
// Define MEM_STAGE_RDATA_BUF_EN to hold load data across WB stalls.
module mem_stage #(
    parameter int EXE_TO_MEM_BUS_WD = 78,
    parameter int MEM_TO_WB_BUS_WD  = 70
) (
    input  logic      clk,
    input  logic      reset,
    mem_stage_if.slave mem_if
);

    logic                         mem_valid_q, mem_valid_d;
    logic [EXE_TO_MEM_BUS_WD-1:0] bus_q, bus_d;
    logic                         first_cyc_q, first_cyc_d;
    logic                         allowin;
    logic                         accept;
    logic                         leave;

    logic        ld_b, ld_bu, ld_h, ld_hu, ld_w;
    logic        load_op, gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result, pc;
    logic [31:0] r;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign allowin = !mem_valid_q | mem_if.wb_allowin;
    assign accept  = mem_if.exe_to_mem_valid & allowin;
    assign leave   = mem_valid_q & mem_if.wb_allowin;

    always_comb begin
        mem_valid_d = mem_valid_q;
        bus_d       = bus_q;
        first_cyc_d = 1'b0;
        if (allowin) mem_valid_d = mem_if.exe_to_mem_valid;
        if (accept) begin
            bus_d       = mem_if.exe_to_mem_bus;
            first_cyc_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
            bus_q       <= '0;
            first_cyc_q <= 1'b0;
        end else begin
            mem_valid_q <= mem_valid_d;
            bus_q       <= bus_d;
            first_cyc_q <= first_cyc_d;
        end
    end

`ifdef MEM_STAGE_RDATA_BUF_EN
    logic [31:0] rdata_buf_q, rdata_buf_d;
    logic        buf_valid_q, buf_valid_d;

    // Capture the SRAM word only when the load stalls in its first cycle.
    always_comb begin
        rdata_buf_d = rdata_buf_q;
        buf_valid_d = buf_valid_q;
        if (first_cyc_q && !mem_if.wb_allowin) begin
            rdata_buf_d = mem_if.data_sram_rdata;
            buf_valid_d = 1'b1;
        end
        if (leave || accept) buf_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_buf_q <= '0;
            buf_valid_q <= 1'b0;
        end else begin
            rdata_buf_q <= rdata_buf_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    assign r = buf_valid_q ? rdata_buf_q : mem_if.data_sram_rdata;
`else
    assign r = mem_if.data_sram_rdata;
`endif

    assign ld_b       = bus_q[77];
    assign ld_bu      = bus_q[76];
    assign ld_h       = bus_q[75];
    assign ld_hu      = bus_q[74];
    assign ld_w       = bus_q[73];
    assign load_op    = bus_q[70];
    assign gr_we      = bus_q[69];
    assign dest       = bus_q[68:64];
    assign alu_result = bus_q[63:32];
    assign pc         = bus_q[31:0];

    always_comb begin
        byte_sel = r[7:0];
        case (alu_result[1:0])
            2'd0: byte_sel = r[7:0];
            2'd1: byte_sel = r[15:8];
            2'd2: byte_sel = r[23:16];
            2'd3: byte_sel = r[31:24];
        endcase
    end

    assign half_sel = alu_result[1] ? r[31:16] : r[15:0];

    always_comb begin
        load_data = '0;
        unique case (1'b1)
            ld_b:    load_data = {{24{byte_sel[7]}}, byte_sel};
            ld_bu:   load_data = {24'h0, byte_sel};
            ld_h:    load_data = {{16{half_sel[15]}}, half_sel};
            ld_hu:   load_data = {16'h0, half_sel};
            ld_w:    load_data = r;
            default: load_data = '0;
        endcase
    end

    assign final_result = load_op ? load_data : alu_result;

    assign mem_if.mem_allowin      = allowin;
    assign mem_if.mem_to_wb_valid  = mem_valid_q;
    assign mem_if.mem_to_wb_bus    = {gr_we, dest, final_result, pc};
    assign mem_if.gr_we_mem        = mem_valid_q & gr_we;
    assign mem_if.dest_mem         = mem_valid_q ? dest : 5'd0;
    assign mem_if.forward_data_mem = mem_valid_q ? final_result : 32'd0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: handshake, load extraction, stalls, reset.
// Expected values are hand-computed constants.
module tb_mem_stage;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mem_stage_if #(.EXE_TO_MEM_BUS_WD(78), .MEM_TO_WB_BUS_WD(70)) bus_if ();

    mem_stage #(.EXE_TO_MEM_BUS_WD(78), .MEM_TO_WB_BUS_WD(70)) dut (
        .clk    (clk),
        .reset  (reset),
        .mem_if (bus_if.slave)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] F_B  = 5'b10000;
    localparam logic [4:0] F_BU = 5'b01000;
    localparam logic [4:0] F_H  = 5'b00100;
    localparam logic [4:0] F_HU = 5'b00010;
    localparam logic [4:0] F_W  = 5'b00001;

    function automatic logic [77:0] mkbus(input logic [4:0] fl, input logic ld,
                                          input logic we, input logic [4:0] d,
                                          input logic [31:0] alu, input logic [31:0] pc);
        return {fl, 1'b0, 1'b0, ld, we, d, alu, pc};
    endfunction

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input string tag, input logic [4:0] fl, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] exp);
        bus_if.exe_to_mem_valid = 1'b1;
        bus_if.exe_to_mem_bus   = mkbus(fl, 1'b1, 1'b1, 5'd7, addr, 32'h1C00_0100);
        step();
        bus_if.exe_to_mem_valid = 1'b0;
        bus_if.data_sram_rdata  = rd;
        #1;
        chk(tag, 70'(bus_if.forward_data_mem), 70'(exp));
    endtask

    initial begin
        reset                   = 1'b1;
        bus_if.exe_to_mem_valid = 1'b0;
        bus_if.exe_to_mem_bus   = '0;
        bus_if.data_sram_rdata  = '0;
        bus_if.wb_allowin       = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        chk("rst_allowin", 70'(bus_if.mem_allowin), 70'(1));
        chk("rst_valid", 70'(bus_if.mem_to_wb_valid), 70'(0));
        chk("rst_gr_we", 70'(bus_if.gr_we_mem), 70'(0));
        chk("rst_dest", 70'(bus_if.dest_mem), 70'(0));
        chk("rst_fwd", 70'(bus_if.forward_data_mem), 70'(0));

        // ALU instruction passes through
        bus_if.exe_to_mem_valid = 1'b1;
        bus_if.exe_to_mem_bus   = mkbus(5'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h1C00_0000);
        step();
        bus_if.exe_to_mem_valid = 1'b0;
        #1;
        chk("add_valid", 70'(bus_if.mem_to_wb_valid), 70'(1));
        chk("add_bus", bus_if.mem_to_wb_bus, {1'b1, 5'd5, 32'h0000_1234, 32'h1C00_0000});
        chk("add_dest", 70'(bus_if.dest_mem), 70'(5));
        chk("add_gr_we", 70'(bus_if.gr_we_mem), 70'(1));
        chk("add_fwd", 70'(bus_if.forward_data_mem), 70'(32'h1234));
        step();
        chk("add_drain", 70'(bus_if.mem_to_wb_valid), 70'(0));
        chk("add_drain_dest", 70'(bus_if.dest_mem), 70'(0));

        // Load extraction
        do_load("ld_b_a3", F_B, 32'h0000_1003, 32'h80FF_1122, 32'hFFFF_FF80);
        do_load("ld_bu_a3", F_BU, 32'h0000_1003, 32'h80FF_1122, 32'h0000_0080);
        do_load("ld_b_a0", F_B, 32'h0000_1000, 32'h80FF_1122, 32'h0000_0022);
        do_load("ld_bu_a2", F_BU, 32'h0000_1002, 32'h80FF_1122, 32'h0000_00FF);
        do_load("ld_h_a2", F_H, 32'h0000_1002, 32'h80FF_1122, 32'hFFFF_80FF);
        do_load("ld_hu_a2", F_HU, 32'h0000_1002, 32'h80FF_1122, 32'h0000_80FF);
        do_load("ld_h_a0", F_H, 32'h0000_1000, 32'h80FF_9122, 32'hFFFF_9122);
        do_load("ld_w", F_W, 32'h0000_1000, 32'h1234_5678, 32'h1234_5678);
        do_load("ld_none", 5'b0, 32'h0000_1000, 32'h1234_5678, 32'h0000_0000);
        step();
        chk("ld_drain", 70'(bus_if.mem_to_wb_valid), 70'(0));

        // Back-to-back ld_w
        bus_if.exe_to_mem_valid = 1'b1;
        bus_if.exe_to_mem_bus   = mkbus(F_W, 1'b1, 1'b1, 5'd3, 32'h0000_2000, 32'h1C00_0200);
        step();
        bus_if.exe_to_mem_bus   = mkbus(F_W, 1'b1, 1'b1, 5'd4, 32'h0000_2004, 32'h1C00_0204);
        bus_if.data_sram_rdata  = 32'h0000_000A;
        #1;
        chk("b2b_a_fwd", 70'(bus_if.forward_data_mem), 70'(32'hA));
        chk("b2b_a_pc", 70'(bus_if.mem_to_wb_bus[31:0]), 70'(32'h1C00_0200));
        chk("b2b_a_allowin", 70'(bus_if.mem_allowin), 70'(1));
        step();
        bus_if.exe_to_mem_valid = 1'b0;
        bus_if.data_sram_rdata  = 32'h0000_000B;
        #1;
        chk("b2b_b_fwd", 70'(bus_if.forward_data_mem), 70'(32'hB));
        chk("b2b_b_pc", 70'(bus_if.mem_to_wb_bus[31:0]), 70'(32'h1C00_0204));
        chk("b2b_b_dest", 70'(bus_if.dest_mem), 70'(4));
        step();

        // ld_w held under a WB stall while SRAM data changes
        bus_if.exe_to_mem_valid = 1'b1;
        bus_if.exe_to_mem_bus   = mkbus(F_W, 1'b1, 1'b1, 5'd9, 32'h0000_3000, 32'h1C00_0300);
        step();
        bus_if.exe_to_mem_valid = 1'b0;
        bus_if.wb_allowin       = 1'b0;
        bus_if.data_sram_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("stall_first_fwd", 70'(bus_if.forward_data_mem), 70'(32'hDEAD_BEEF));
        chk("stall_first_allowin", 70'(bus_if.mem_allowin), 70'(0));
        for (int i = 0; i < 3; i++) begin
            step();
            bus_if.data_sram_rdata  = 32'h0;
            bus_if.exe_to_mem_valid = 1'b1;
            bus_if.exe_to_mem_bus   = mkbus(F_W, 1'b1, 1'b1, 5'd1, 32'h0, 32'h1C00_0999);
            #1;
            chk("stall_valid", 70'(bus_if.mem_to_wb_valid), 70'(1));
            chk("stall_allowin", 70'(bus_if.mem_allowin), 70'(0));
            chk("stall_pc", 70'(bus_if.mem_to_wb_bus[31:0]), 70'(32'h1C00_0300));
`ifdef MEM_STAGE_RDATA_BUF_EN
            chk("stall_fwd", 70'(bus_if.forward_data_mem), 70'(32'hDEAD_BEEF));
`else
            chk("stall_fwd", 70'(bus_if.forward_data_mem), 70'(32'h0));
`endif
        end
        bus_if.exe_to_mem_valid = 1'b0;
        bus_if.wb_allowin       = 1'b1;
        #1;
        chk("release_allowin", 70'(bus_if.mem_allowin), 70'(1));
        step();
        chk("release_empty", 70'(bus_if.mem_to_wb_valid), 70'(0));

        // Reset while holding a load
        bus_if.exe_to_mem_valid = 1'b1;
        bus_if.exe_to_mem_bus   = mkbus(F_W, 1'b1, 1'b1, 5'd12, 32'h0000_4000, 32'h1C00_0400);
        step();
        bus_if.exe_to_mem_valid = 1'b0;
        bus_if.wb_allowin       = 1'b0;
        #1;
        chk("hold_pre_rst", 70'(bus_if.gr_we_mem), 70'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("midrst_valid", 70'(bus_if.mem_to_wb_valid), 70'(0));
        chk("midrst_gr_we", 70'(bus_if.gr_we_mem), 70'(0));
        chk("midrst_dest", 70'(bus_if.dest_mem), 70'(0));
        chk("midrst_allowin", 70'(bus_if.mem_allowin), 70'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
